// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_GROUP = 4;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   function automatic int num_groups(input int width, input int group);
      return width / group;
   endfunction

endpackage

// File: rtl/cla_group.sv
// One lookahead group: per-bit propagate plus the group propagate/generate pair.
module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = DEFAULT_GROUP
)(
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   output logic [GROUP-1:0] p,
   output pg_t              grp
);

   logic [GROUP-1:0] w_g;
   logic             w_gacc;

   always_comb begin
      p      = a ^ b;
      w_g    = a & b;
      w_gacc = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
         w_gacc = w_g[i] | (p[i] & w_gacc);
      end
      grp.p = &p;
      grp.g = w_gacc;
   end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage valid/ready carry-lookahead adder. Define APPROX_LOWER_EN for the
// lower-part-OR approximation over the low APPROX_BITS bits.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int GROUP       = DEFAULT_GROUP,
   parameter int APPROX_BITS = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NG = num_groups(WIDTH, GROUP);

   // Handshake: a stage accepts when it is empty or its content moves on this cycle.
   logic w_s2_adv;
   logic r_s1_valid, r_s2_valid;

   assign w_s2_adv = !r_s2_valid || out_ready;
   assign in_ready = !r_s1_valid || w_s2_adv;

   logic [WIDTH-1:0] w_a_eff, w_b_eff;
   logic             w_cin_eff;
`ifdef APPROX_LOWER_EN
   logic             w_fix, r_s1_fix;
`endif

   // Approximation is folded into the operands: low bits become (a|b)+0 with
   // no carry, and the top approximate bit keeps a/b so it emits a&b as carry.
   always_comb begin
      w_a_eff   = a;
      w_b_eff   = b;
      w_cin_eff = cin;
`ifdef APPROX_LOWER_EN
      w_cin_eff = 1'b0;
      w_fix     = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i < APPROX_BITS - 1) begin
            w_a_eff[i] = a[i] | b[i];
            w_b_eff[i] = 1'b0;
         end
         if (i == APPROX_BITS - 1) begin
            w_fix = a[i] & b[i];
         end
      end
`endif
   end

   logic [WIDTH-1:0] w_p;
   pg_t              w_pg [NG];

   for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
         .a   (w_a_eff[j*GROUP +: GROUP]),
         .b   (w_b_eff[j*GROUP +: GROUP]),
         .p   (w_p[j*GROUP +: GROUP]),
         .grp (w_pg[j])
      );
   end

   logic [WIDTH-1:0] r_s1_p, r_s1_g;
   logic [NG-1:0]    r_s1_gp, r_s1_gg;
   logic             r_s1_cin, r_s1_amsb, r_s1_bmsb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_p     <= '0;
         r_s1_g     <= '0;
         r_s1_gp    <= '0;
         r_s1_gg    <= '0;
         r_s1_cin   <= 1'b0;
         r_s1_amsb  <= 1'b0;
         r_s1_bmsb  <= 1'b0;
`ifdef APPROX_LOWER_EN
         r_s1_fix   <= 1'b0;
`endif
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_p    <= w_p;
            r_s1_g    <= w_a_eff & w_b_eff;
            for (int j = 0; j < NG; j++) begin
               r_s1_gp[j] <= w_pg[j].p;
               r_s1_gg[j] <= w_pg[j].g;
            end
            r_s1_cin  <= w_cin_eff;
            r_s1_amsb <= a[WIDTH-1];
            r_s1_bmsb <= b[WIDTH-1];
`ifdef APPROX_LOWER_EN
            r_s1_fix  <= w_fix;
`endif
         end
      end
   end

   logic [NG:0]      w_gc;
   logic [WIDTH-1:0] w_c, w_sum;
   logic             w_rc, w_ovf;

   // Group carries by lookahead, then ripple inside each group from its carry-in.
   always_comb begin
      w_gc    = '0;
      w_gc[0] = r_s1_cin;
      for (int j = 0; j < NG; j++) begin
         w_gc[j+1] = r_s1_gg[j] | (r_s1_gp[j] & w_gc[j]);
      end
      w_c  = '0;
      w_rc = 1'b0;
      for (int j = 0; j < NG; j++) begin
         w_rc = w_gc[j];
         for (int k = 0; k < GROUP; k++) begin
            w_c[j*GROUP+k] = w_rc;
            w_rc = r_s1_g[j*GROUP+k] | (r_s1_p[j*GROUP+k] & w_rc);
         end
      end
      w_sum = r_s1_p ^ w_c;
`ifdef APPROX_LOWER_EN
      for (int i = 0; i < WIDTH; i++) begin
         if (i == APPROX_BITS - 1) begin
            w_sum[i] = w_sum[i] | r_s1_fix;
         end
      end
`endif
      w_ovf = (r_s1_amsb == r_s1_bmsb) && (w_sum[WIDTH-1] != r_s1_amsb);
   end

   logic [WIDTH-1:0] r_sum;
   logic             r_cout, r_ovf;

   // Results are zeroed whenever stage 2 goes empty so idle outputs read 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_sum      <= '0;
         r_cout     <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         r_sum      <= r_s1_valid ? w_sum : '0;
         r_cout     <= r_s1_valid ? w_gc[NG] : 1'b0;
         r_ovf      <= r_s1_valid ? w_ovf : 1'b0;
      end
   end

   assign out_valid = r_s2_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and sum width in bits; legal range 4..64.
REQ-002 SHALL have parameter GROUP, default 4, lookahead group width in bits; WIDTH SHALL be a multiple of GROUP.
REQ-003 SHALL have parameter APPROX_BITS, default 4, number of low-order bits computed approximately; legal range 0..WIDTH-GROUP; used only when APPROX_LOWER_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operands are presented.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-008 SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-009 SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-010 SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-011 SHALL have port out_valid, output, 1 bit: sum, cout and ovf are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port sum, output, WIDTH bits: a+b+cin modulo 2^WIDTH.
REQ-014 SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-015 SHALL have port ovf, output, 1 bit: signed overflow, (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).

Function
REQ-016 SHALL register operands as a transfer when in_valid && in_ready.
REQ-017 Stage 1 SHALL register per-bit propagate (a^b), per-group propagate and generate for each of WIDTH/GROUP groups, cin, and the operand MSBs.
REQ-018 Stage 2 SHALL compute group carries by lookahead from the stage-1 group P/G and cin, then register sum, cout and ovf.
REQ-019 Latency SHALL be exactly 2 cycles from accepting transfer to out_valid with no backpressure; throughput SHALL be 1 result per cycle.
REQ-020 Each stage SHALL hold a valid bit; a stage SHALL load when it is empty or its contents move on in the same cycle.
REQ-021 When out_valid && !out_ready, sum, cout and ovf SHALL stay stable and in_ready SHALL deassert once both stages are full.
REQ-022 in_ready SHALL be combinationally !(s1_valid && s2_valid && !out_ready); a simultaneous accept and output drain SHALL lose no data and duplicate none.
REQ-023 Results SHALL leave in acceptance order.
REQ-024 Operands SHALL be ignored when in_valid is low; register contents of an empty stage are don't-care but outputs SHALL be 0 while out_valid is 0.

Reset
REQ-025 While rst_n is low, all valid bits SHALL be 0; out_valid, sum, cout and ovf SHALL be 0; in_ready SHALL be 1 after reset release.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight results, and none SHALL appear after release.

Configuration
REQ-027 Macro APPROX_LOWER_EN SHALL control the approximate lower part. When defined, sum[APPROX_BITS-1:0] = a|b over those bits, cin SHALL be ignored, and the carry into bit APPROX_BITS SHALL be a[APPROX_BITS-1]&b[APPROX_BITS-1] (lower-part-OR style). Upper bits SHALL use exact lookahead.
REQ-028 When APPROX_LOWER_EN is undefined, the adder SHALL be exact over all WIDTH bits and APPROX_BITS SHALL have no effect.

Structure
REQ-029 Package cla_pkg SHALL hold default WIDTH/GROUP constants, a num_groups(WIDTH,GROUP) function, and a typedef for the group P/G pair.
REQ-030 SHALL instantiate sub-module cla_group (GROUP-bit block: inputs a, b; outputs per-bit p, group P, group G) once per group via generate.

Verification (WIDTH=16, GROUP=4, APPROX_BITS=4)
REQ-031 Exact build, 0xFFFF+0x0001, cin=0 -> two cycles later sum=0x0000, cout=1, ovf=0.
REQ-032 Exact build, 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; 0x1234+0x4321, cin=1 -> 0x5556.
REQ-033 Back-to-back stream of 8 operands with out_ready held 0 for 3 cycles mid-stream -> in_ready drops after 2 are held; all 8 results arrive in order, none lost or duplicated.
REQ-034 rst_n pulsed low while both stages are valid -> out_valid=0 immediately; no stale result after release; next input returns after 2 cycles.
REQ-035 APPROX_LOWER_EN build: 0x000F+0x0001 -> sum=0x000F; 0x0008+0x0008 -> sum=0x0018; exact build gives 0x0010 for both.
